// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: glitch-filtered clock, odd parity, framing and stall checks.
// Latency: strobe one cycle after the filtered fall that samples the stop bit.
// No backpressure: SCAN_CODE holds until the next good byte. Optional prefix decode: PS2_RX_BREAK_DECODE_EN.
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] SCAN_CODE,
    output logic       SCAN_VALID,
    output logic       PARITY_ERR,
    output logic       FRAME_ERR,
    output logic       BREAK,
    output logic       EXTENDED,
    output logic       BUSY
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic            clk_meta, clk_sync, dat_meta, dat_sync;
    logic            filt_clk;
    logic [FW-1:0]   filt_cnt;
    logic [TW-1:0]   to_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [2:0]      bit_cnt;
    logic            pend_brk, pend_ext;
    logic            is_prefix;

    logic filt_fall, timeout, stop_fall, parity_ok, commit_now, err_now;

    // Filtered clock falls on the cycle the counter confirms a stable low.
    assign filt_fall  = filt_clk && !clk_sync && (filt_cnt == FILT_LAST);
    assign timeout    = (state != IDLE) && !filt_fall && (to_cnt == TO_LAST);
    assign stop_fall  = filt_fall && (state == STOP);
    assign parity_ok  = ^{shreg, par_bit};
    assign commit_now = stop_fall && dat_sync && parity_ok;
    assign err_now    = (stop_fall && !(dat_sync && parity_ok)) || timeout
                      || (filt_fall && (state == IDLE) && dat_sync);

    // Two-flop synchronizers; idle level of both pads is high.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK;
            clk_sync <= clk_meta;
            dat_meta <= PS2_DATA;
            dat_sync <= dat_meta;
        end
    end

    // Glitch filter: follow the synchronized clock only after FILTER_LEN equal samples.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FILT_LAST) begin
            filt_clk <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Stall timer: restarts on every filtered fall and while idle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            to_cnt <= '0;
        end else if ((state == IDLE) || filt_fall) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

`ifdef PS2_RX_BREAK_DECODE_EN
    assign is_prefix = (shreg == 8'hE0) || (shreg == 8'hF0);

    // Pending prefix flags: set by good E0/F0, consumed by the next good code, dropped on errors.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pend_brk <= 1'b0;
            pend_ext <= 1'b0;
        end else if (err_now) begin
            pend_brk <= 1'b0;
            pend_ext <= 1'b0;
        end else if (commit_now) begin
            if (shreg == 8'hE0) begin
                pend_ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
                pend_brk <= 1'b1;
            end else begin
                pend_brk <= 1'b0;
                pend_ext <= 1'b0;
            end
        end
    end
`else
    assign is_prefix = 1'b0;
    assign pend_brk  = 1'b0;
    assign pend_ext  = 1'b0;
`endif

    // Frame FSM with registered strobes, code, qualifiers and BUSY.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            shreg      <= '0;
            par_bit    <= 1'b0;
            bit_cnt    <= '0;
            SCAN_CODE  <= '0;
            SCAN_VALID <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            BREAK      <= 1'b0;
            EXTENDED   <= 1'b0;
            BUSY       <= 1'b0;
        end else begin
            SCAN_VALID <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            if (filt_fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_sync) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            BUSY    <= 1'b1;
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= dat_sync;
                        state   <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                        if (!dat_sync) begin
                            FRAME_ERR <= 1'b1;
                        end else if (!parity_ok) begin
                            PARITY_ERR <= 1'b1;
                        end else if (!is_prefix) begin
                            SCAN_CODE  <= shreg;
                            SCAN_VALID <= 1'b1;
                            BREAK      <= pend_brk;
                            EXTENDED   <= pend_ext;
                        end
                    end
                endcase
            end else if (timeout) begin
                state     <= IDLE;
                BUSY      <= 1'b0;
                FRAME_ERR <= 1'b1;
            end
        end
    end

endmodule
